transpose_buf: RTL and testbench

TRANSPOSE_BUF -- requirements
Module: transpose_buf

---
 rtl/transpose_buf_if.sv | 27 ++
 rtl/transpose_buf.sv | 114 +++++++++++
 tb/tb_transpose_buf.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/transpose_buf_if.sv
// Stream bundle for transpose_buf: input beat handshake with frame mode,
// output beat handshake, and the sticky overflow flag.
interface transpose_buf_if #(
    parameter int DATA_W = 34,
    parameter int LANES  = 4
);
    logic                    in_valid;
    logic                    in_ready;
    logic [LANES*DATA_W-1:0] data_in;
    logic                    mode_tr;
    logic                    out_valid;
    logic                    out_ready;
    logic [LANES*DATA_W-1:0] data_out;
    logic                    ovf_err;

    // Upstream/downstream side: produces input beats and consumes output beats.
    modport master (
        output in_valid, data_in, mode_tr, out_ready,
        input  in_ready, out_valid, data_out, ovf_err
    );

    // Buffer side.
    modport slave (
        input  in_valid, data_in, mode_tr, out_ready,
        output in_ready, out_valid, data_out, ovf_err
    );
endinterface

// File: rtl/transpose_buf.sv
// transpose_buf: ping-pong LANES x LANES frame buffer.
// A frame is LANES beats of LANES words. Each bank remembers the mode seen on
// its first beat; on readout a transpose frame emits column m as beat m, a
// bypass frame replays its input beats unchanged.
//
// Storage is one flat array addressed {bank, beat, lane} so both the row and
// the column read paths are plain indexed lookups with exact-width addresses.
module transpose_buf #(
    parameter int DATA_W = 34,
    parameter int LANES  = 4
) (
    input logic            clk,
    input logic            rst_n,
    transpose_buf_if.slave bus
);
    localparam int CW    = $clog2(LANES);
    localparam int AW    = 1 + 2 * CW;
    localparam int DEPTH = 2 * LANES * LANES;
    localparam int BW    = LANES * DATA_W;
    localparam logic [CW-1:0] LAST = CW'(LANES - 1);

    logic [DATA_W-1:0] mem [DEPTH];

    logic          wr_ptr;
    logic          rd_ptr;
    logic [CW-1:0] wr_cnt;
    logic [CW-1:0] rd_cnt;
    logic [1:0]    full;
    logic [1:0]    full_nxt;
    logic [1:0]    mode_q;
    logic          ovf_q;

    logic          accept;
    logic          xfer;
    logic          wr_last;
    logic          rd_last;
    logic [BW-1:0] rd_tr;
    logic [BW-1:0] rd_by;

    // A bank that is full is never the write target, and a bank that is not
    // full is never read, so a write and a read never collide on one bank.
    assign accept  = bus.in_valid & ~full[wr_ptr];
    assign xfer    = bus.out_ready & full[rd_ptr];
    assign wr_last = accept & (wr_cnt == LAST);
    assign rd_last = xfer & (rd_cnt == LAST);

    assign bus.in_ready  = ~full[wr_ptr];
    assign bus.out_valid = full[rd_ptr];
    assign bus.ovf_err   = ovf_q;
    assign bus.data_out  = full[rd_ptr] ? (mode_q[rd_ptr] ? rd_tr : rd_by) : '0;

    // Next full flags: completing a write and completing a read in the same
    // cycle touch different banks, so both updates land.
    always_comb begin
        full_nxt = full;
        if (rd_last) full_nxt[rd_ptr] = 1'b0;
        if (wr_last) full_nxt[wr_ptr] = 1'b1;
    end

    // Word storage: write every lane of an accepted beat into row wr_cnt.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int j = 0; j < LANES; j++) begin
                mem[AW'({wr_ptr, wr_cnt, CW'(j)})] <= bus.data_in[j*DATA_W +: DATA_W];
            end
        end
    end

    // Read paths: column rd_cnt (transpose) and row rd_cnt (bypass) of the read bank.
    always_comb begin
        rd_tr = '0;
        rd_by = '0;
        for (int k = 0; k < LANES; k++) begin
            rd_tr[k*DATA_W +: DATA_W] = mem[AW'({rd_ptr, CW'(k), rd_cnt})];
            rd_by[k*DATA_W +: DATA_W] = mem[AW'({rd_ptr, rd_cnt, CW'(k)})];
        end
    end

    // Write side control: beat counter, bank pointer and per-bank mode latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt <= '0;
            wr_ptr <= 1'b0;
            mode_q <= '0;
        end else if (accept) begin
            if (wr_cnt == '0) mode_q[wr_ptr] <= bus.mode_tr;
            wr_cnt <= wr_cnt + 1'b1;
            if (wr_last) wr_ptr <= ~wr_ptr;
        end
    end

    // Read side control: beat counter and bank pointer, advancing only on a transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt <= '0;
            rd_ptr <= 1'b0;
        end else if (xfer) begin
            rd_cnt <= rd_cnt + 1'b1;
            if (rd_last) rd_ptr <= ~rd_ptr;
        end
    end

    // Bank occupancy flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) full <= '0;
        else        full <= full_nxt;
    end

    // Sticky overflow: a beat offered while the write bank is still full is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                             ovf_q <= 1'b0;
        else if (bus.in_valid && full[wr_ptr])  ovf_q <= 1'b1;
    end
endmodule

// File: tb/tb_transpose_buf.sv
// Bench for transpose_buf: directed frames from the word pattern 16*b+j,
// streaming, backpressure, mid-frame reset, random traffic against a
// queue-based frame model, and LANES=2/8 instances.
module tb_transpose_buf;
    localparam int DW = 34;
    localparam int L  = 4;
    localparam int BW = L * DW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    transpose_buf_if #(.DATA_W(DW), .LANES(L)) bus  ();
    transpose_buf_if #(.DATA_W(DW), .LANES(2)) bus2 ();
    transpose_buf_if #(.DATA_W(DW), .LANES(8)) bus8 ();

    transpose_buf #(.DATA_W(DW), .LANES(L)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    transpose_buf #(.DATA_W(DW), .LANES(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
    transpose_buf #(.DATA_W(DW), .LANES(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

    int total = 0;
    int bad   = 0;

    // Reference model: the partial frame being collected, and the queue of
    // output beats of completed frames still waiting to leave.
    logic [DW-1:0] part [L][L];
    int            part_n;
    logic          part_mode;
    logic [BW-1:0] oq [$];
    logic          ovf_m;

    function automatic int frames_held();
        return (oq.size() + L - 1) / L;
    endfunction

    function automatic logic exp_in_ready();
        return frames_held() < 2;
    endfunction

    function automatic logic exp_out_valid();
        return oq.size() > 0;
    endfunction

    function automatic logic [BW-1:0] exp_data();
        return (oq.size() > 0) ? oq[0] : '0;
    endfunction

    function automatic logic [BW-1:0] pat_beat(input int b);
        logic [BW-1:0] v;
        v = '0;
        for (int j = 0; j < L; j++) v[j*DW +: DW] = DW'(16 * b + j);
        return v;
    endfunction

    function automatic logic [BW-1:0] rand_beat();
        logic [BW-1:0] v;
        v = '0;
        for (int j = 0; j < L; j++) v[j*DW +: DW] = DW'({$urandom(), $urandom()});
        return v;
    endfunction

    task automatic model_reset();
        oq.delete();
        part_n    = 0;
        part_mode = 1'b0;
        ovf_m     = 1'b0;
    endtask

    // Apply one cycle of stimulus to the LANES=4 instance and advance the model.
    // Starts and ends 1 time unit after a rising edge.
    task automatic drive_cycle(input logic iv, input logic [BW-1:0] d,
                               input logic md, input logic ordy);
        logic          acc;
        logic          xfr;
        logic [BW-1:0] beat;
        bus.in_valid  = iv;
        bus.data_in   = d;
        bus.mode_tr   = md;
        bus.out_ready = ordy;
        acc = iv && exp_in_ready();
        xfr = ordy && exp_out_valid();
        if (iv && !exp_in_ready()) ovf_m = 1'b1;
        @(posedge clk);
        if (xfr) void'(oq.pop_front());
        if (acc) begin
            if (part_n == 0) part_mode = md;
            for (int j = 0; j < L; j++) part[part_n][j] = d[j*DW +: DW];
            part_n++;
            if (part_n == L) begin
                for (int m = 0; m < L; m++) begin
                    beat = '0;
                    for (int k = 0; k < L; k++)
                        beat[k*DW +: DW] = part_mode ? part[k][m] : part[m][k];
                    oq.push_back(beat);
                end
                part_n = 0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0; bus.data_in = '0; bus.mode_tr = 1'b0; bus.out_ready = 1'b0;
        bus2.in_valid = 1'b0; bus2.data_in = '0; bus2.mode_tr = 1'b0; bus2.out_ready = 1'b0;
        bus8.in_valid = 1'b0; bus8.data_in = '0; bus8.mode_tr = 1'b0; bus8.out_ready = 1'b0;
        model_reset();
        rst_n = 1'b0;
        #3;
        total++; if (bus.in_ready !== 1'b1)
            begin bad++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        total++; if (bus.out_valid !== 1'b0)
            begin bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        total++; if (bus.data_out !== '0)
            begin bad++; $display("FAIL reset_data_out: got %h want 0", bus.data_out); end
        total++; if (bus.ovf_err !== 1'b0)
            begin bad++; $display("FAIL reset_ovf_err: got %b want 0", bus.ovf_err); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Directed frame with the 16*b+j pattern; expected words come straight
    // from the frame rules (transpose: lane k of beat m = 16k+m).
    task automatic run_pattern_frame(input logic md, input string tag);
        logic [BW-1:0] exp;
        for (int b = 0; b < L; b++) begin
            drive_cycle(1'b1, pat_beat(b), md, 1'b1);
            total++; if (bus.out_valid !== (b == L - 1))
                begin bad++; $display("FAIL %s_latency beat%0d: got %b want %b", tag, b, bus.out_valid, (b == L - 1)); end
        end
        for (int m = 0; m < L; m++) begin
            exp = '0;
            for (int k = 0; k < L; k++)
                exp[k*DW +: DW] = md ? DW'(16 * k + m) : DW'(16 * m + k);
            total++; if (bus.data_out !== exp)
                begin bad++; $display("FAIL %s_data beat%0d: got %h want %h", tag, m, bus.data_out, exp); end
            drive_cycle(1'b0, '0, 1'b0, 1'b1);
        end
        total++; if (bus.out_valid !== 1'b0 || bus.data_out !== '0)
            begin bad++; $display("FAIL %s_drained: got valid=%b data=%h want 0/0", tag, bus.out_valid, bus.data_out); end
    endtask

    task automatic test_transpose();
        run_pattern_frame(1'b1, "transpose");
    endtask

    task automatic test_bypass();
        run_pattern_frame(1'b0, "bypass");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3 * L + L + 1; i++) begin
            if (i < 3 * L) begin
                total++; if (bus.in_ready !== 1'b1)
                    begin bad++; $display("FAIL b2b_in_ready cyc%0d: got %b want 1", i, bus.in_ready); end
            end
            total++; if (bus.out_valid !== (i >= L && i < 4 * L))
                begin bad++; $display("FAIL b2b_out_valid cyc%0d: got %b want %b", i, bus.out_valid, (i >= L && i < 4 * L)); end
            total++; if (bus.data_out !== exp_data())
                begin bad++; $display("FAIL b2b_data cyc%0d: got %h want %h", i, bus.data_out, exp_data()); end
            if (i < 3 * L) drive_cycle(1'b1, rand_beat(), ((i / L) % 2) == 0, 1'b1);
            else           drive_cycle(1'b0, '0, 1'b0, 1'b1);
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 2 * L + 1; i++) begin
            total++; if (bus.in_ready !== (i < 2 * L))
                begin bad++; $display("FAIL bp_in_ready beat%0d: got %b want %b", i, bus.in_ready, (i < 2 * L)); end
            if (i == 2 * L) begin
                total++; if (bus.ovf_err !== 1'b0)
                    begin bad++; $display("FAIL bp_ovf_early: got %b want 0", bus.ovf_err); end
            end
            drive_cycle(1'b1, rand_beat(), 1'($urandom_range(0, 1)), 1'b0);
        end
        total++; if (bus.ovf_err !== 1'b1)
            begin bad++; $display("FAIL bp_ovf_set: got %b want 1", bus.ovf_err); end
        for (int i = 0; i < 2 * L + 1; i++) begin
            total++; if (bus.out_valid !== (i < 2 * L))
                begin bad++; $display("FAIL bp_drain_valid beat%0d: got %b want %b", i, bus.out_valid, (i < 2 * L)); end
            total++; if (bus.data_out !== exp_data())
                begin bad++; $display("FAIL bp_drain_data beat%0d: got %h want %h", i, bus.data_out, exp_data()); end
            drive_cycle(1'b0, '0, 1'b0, 1'b1);
        end
    endtask

    task automatic test_random();
        int thresh;
        for (int i = 0; i < 600; i++) begin
            thresh = ((i / 100) % 2 == 0) ? 85 : 30;
            total++; if (bus.in_ready !== exp_in_ready())
                begin bad++; $display("FAIL rnd_in_ready cyc%0d: got %b want %b", i, bus.in_ready, exp_in_ready()); end
            total++; if (bus.out_valid !== exp_out_valid())
                begin bad++; $display("FAIL rnd_out_valid cyc%0d: got %b want %b", i, bus.out_valid, exp_out_valid()); end
            total++; if (bus.data_out !== exp_data())
                begin bad++; $display("FAIL rnd_data cyc%0d: got %h want %h", i, bus.data_out, exp_data()); end
            total++; if (bus.ovf_err !== ovf_m)
                begin bad++; $display("FAIL rnd_ovf cyc%0d: got %b want %b", i, bus.ovf_err, ovf_m); end
            drive_cycle($urandom_range(0, 3) != 0, rand_beat(), 1'($urandom_range(0, 1)),
                        $urandom_range(0, 99) < thresh);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < L + 2; i++) drive_cycle(1'b1, rand_beat(), 1'b1, 1'b0);
        total++; if (bus.out_valid !== 1'b1)
            begin bad++; $display("FAIL midrst_pre_valid: got %b want 1", bus.out_valid); end
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        total++; if (bus.out_valid !== 1'b0)
            begin bad++; $display("FAIL midrst_out_valid: got %b want 0", bus.out_valid); end
        total++; if (bus.data_out !== '0)
            begin bad++; $display("FAIL midrst_data_out: got %h want 0", bus.data_out); end
        total++; if (bus.in_ready !== 1'b1)
            begin bad++; $display("FAIL midrst_in_ready: got %b want 1", bus.in_ready); end
        total++; if (bus.ovf_err !== 1'b0)
            begin bad++; $display("FAIL midrst_ovf: got %b want 0", bus.ovf_err); end
        model_reset();
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_pattern_frame(1'b1, "midrst_tr");
    endtask

    task automatic test_lanes2();
        bus2.mode_tr = 1'b1; bus2.out_ready = 1'b1;
        for (int b = 0; b < 2; b++) begin
            bus2.in_valid = 1'b1;
            for (int j = 0; j < 2; j++) bus2.data_in[j*DW +: DW] = DW'(16 * b + j);
            @(posedge clk); #1;
        end
        bus2.in_valid = 1'b0;
        for (int m = 0; m < 2; m++) begin
            total++; if (bus2.out_valid !== 1'b1)
                begin bad++; $display("FAIL l2_valid beat%0d: got %b want 1", m, bus2.out_valid); end
            for (int k = 0; k < 2; k++) begin
                total++; if (bus2.data_out[k*DW +: DW] !== DW'(16 * k + m))
                    begin bad++; $display("FAIL l2_data beat%0d lane%0d: got %0d want %0d", m, k, bus2.data_out[k*DW +: DW], 16 * k + m); end
            end
            @(posedge clk); #1;
        end
        total++; if (bus2.out_valid !== 1'b0)
            begin bad++; $display("FAIL l2_drained: got %b want 0", bus2.out_valid); end
    endtask

    task automatic test_lanes8();
        bus8.mode_tr = 1'b1; bus8.out_ready = 1'b1;
        for (int b = 0; b < 8; b++) begin
            bus8.in_valid = 1'b1;
            for (int j = 0; j < 8; j++) bus8.data_in[j*DW +: DW] = DW'(16 * b + j);
            @(posedge clk); #1;
        end
        bus8.in_valid = 1'b0;
        for (int m = 0; m < 8; m++) begin
            total++; if (bus8.out_valid !== 1'b1)
                begin bad++; $display("FAIL l8_valid beat%0d: got %b want 1", m, bus8.out_valid); end
            for (int k = 0; k < 8; k++) begin
                total++; if (bus8.data_out[k*DW +: DW] !== DW'(16 * k + m))
                    begin bad++; $display("FAIL l8_data beat%0d lane%0d: got %0d want %0d", m, k, bus8.data_out[k*DW +: DW], 16 * k + m); end
            end
            @(posedge clk); #1;
        end
        total++; if (bus8.out_valid !== 1'b0)
            begin bad++; $display("FAIL l8_drained: got %b want 0", bus8.out_valid); end
    endtask

    initial begin
        test_reset();
        test_transpose();
        test_bypass();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_mid();
        test_lanes2();
        test_lanes8();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
